// File: rtl/answer_checker_pkg.sv
// Shared types for the number-game answer checker: FSM states, verdict codes
// and a counter-width helper.
package game_pkg;

    localparam int DATA_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQUEST = 3'd1,
        SETTLE  = 3'd2,
        ARMED   = 3'd3,
        RESULT  = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] V_NONE    = 2'b00;
    localparam logic [1:0] V_OK      = 2'b01;
    localparam logic [1:0] V_WRONG   = 2'b10;
    localparam logic [1:0] V_TIMEOUT = 2'b11;

    // Bits needed to hold a count of 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/answer_checker_if.sv
// Board/generator/display signal bundle for answer_checker; the checker
// connects through the slave modport, its environment through master.
interface answer_checker_if #(
    parameter int DATA_W  = game_pkg::DATA_W_DEF,
    parameter int SCORE_W = 8
);
    // gen_enable is a one-cycle request; gen_result must be stable by the last
    // settle cycle. verdict is meaningful only while verdict_valid is high.
    logic              start;
    logic              submit;
    logic [DATA_W-1:0] switches;
    logic [DATA_W-1:0] gen_result;
    logic              gen_enable;
    logic [DATA_W-1:0] target;
    logic              round_active;
    logic              verdict_valid;
    logic [1:0]        verdict;
    logic [SCORE_W-1:0] score;
    logic [7:0]        round_num;
    logic              game_done;

    modport slave (
        input  start, submit, switches, gen_result,
        output gen_enable, target, round_active, verdict_valid,
               verdict, score, round_num, game_done
    );

    modport master (
        output start, submit, switches, gen_result,
        input  gen_enable, target, round_active, verdict_valid,
               verdict, score, round_num, game_done
    );

endinterface

// File: rtl/answer_checker_rise_detect.sv
// Registered rising-edge detector: rise_o is high for the cycle after sig_i
// is first seen high.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
            rise_q <= sig_i & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/answer_checker.sv
// Number-game answer checker: requests a target, arms a round, judges the
// player's answer and keeps score. Optional timeout: ANSWER_TIMEOUT_EN.
module answer_checker
    import game_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int SCORE_W     = 8,
    parameter int ROUNDS      = 10,
    parameter int SETTLE_CYC  = 2,
    parameter int SHOW_CYC    = 50_000_000,
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input  logic               clk,
    input  logic               rst,
    answer_checker_if.slave    bus,
    output state_t             dbg_state_o
);

    localparam int PH_MAX = (SETTLE_CYC > SHOW_CYC) ? SETTLE_CYC : SHOW_CYC;
    localparam int PH_W   = cnt_w(PH_MAX);
    localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
    localparam logic [PH_W-1:0] SHOW_LAST   = PH_W'(SHOW_CYC - 1);
    localparam logic [7:0]      ROUNDS_LAST = 8'(ROUNDS);

    state_t              state_q, state_d;
    logic [PH_W-1:0]     ph_cnt_q, ph_cnt_d;
    logic [DATA_W-1:0]   target_q, target_d;
    logic [1:0]          verdict_q, verdict_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [7:0]          round_q, round_d;
    logic                start_rise;
    logic                submit_rise;
    logic                timeout_hit;
    logic                answer_ok;

    rise_detect u_start_rise (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (bus.start),
        .rise_o (start_rise)
    );

    rise_detect u_submit_rise (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (bus.submit),
        .rise_o (submit_rise)
    );

`ifdef ANSWER_TIMEOUT_EN
    localparam int TO_W = cnt_w(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt_q;

    // Held at zero outside ARMED so every round starts its timeout fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (state_q != ARMED) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == ARMED) && (to_cnt_q == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    assign answer_ok = (bus.switches == target_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ph_cnt_q  <= '0;
            target_q  <= '0;
            verdict_q <= V_NONE;
            score_q   <= '0;
            round_q   <= '0;
        end else begin
            state_q   <= state_d;
            ph_cnt_q  <= ph_cnt_d;
            target_q  <= target_d;
            verdict_q <= verdict_d;
            score_q   <= score_d;
            round_q   <= round_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ph_cnt_d  = ph_cnt_q;
        target_d  = target_q;
        verdict_d = verdict_q;
        score_d   = score_q;
        round_d   = round_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    score_d  = '0;
                    round_d  = '0;
                    ph_cnt_d = '0;
                    state_d  = REQUEST;
                end
            end
            REQUEST: begin
                ph_cnt_d = '0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (ph_cnt_q == SETTLE_LAST) begin
                    target_d = bus.gen_result;
                    ph_cnt_d = '0;
                    state_d  = ARMED;
                end else begin
                    ph_cnt_d = ph_cnt_q + 1'b1;
                end
            end
            ARMED: begin
                // A submit arriving in the expiry cycle still counts as an answer.
                if (submit_rise || timeout_hit) begin
                    if (submit_rise) begin
                        verdict_d = answer_ok ? V_OK : V_WRONG;
                    end else begin
                        verdict_d = V_TIMEOUT;
                    end
                    if (submit_rise && answer_ok && (score_q != '1)) begin
                        score_d = score_q + 1'b1;
                    end
                    round_d  = round_q + 1'b1;
                    ph_cnt_d = '0;
                    state_d  = RESULT;
                end
            end
            RESULT: begin
                if (ph_cnt_q == SHOW_LAST) begin
                    verdict_d = V_NONE;
                    ph_cnt_d  = '0;
                    state_d   = (round_q == ROUNDS_LAST) ? DONE : REQUEST;
                end else begin
                    ph_cnt_d = ph_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gen_enable    = (state_q == REQUEST);
    assign bus.target        = target_q;
    assign bus.round_active  = (state_q == ARMED);
    assign bus.verdict_valid = (state_q == RESULT);
    assign bus.verdict       = verdict_q;
    assign bus.score         = score_q;
    assign bus.round_num     = round_q;
    assign bus.game_done     = (state_q == DONE);
    assign dbg_state_o       = state_q;

endmodule
